sdram_burst_writer: RTL
=======================

SDRAM_BURST_WRITER -- requirements
Module: sdram_burst_writer

Interface
REQ-001 Parameter DATA_W, 16, SDRAM data bus width.
REQ-002 Parameter BANK_W, 2, bank address width.
REQ-003 Parameter ROW_W, 13, row address width; SHALL be >= 11 so that A10 exists.
REQ-004 Parameter COL_W, 9, column address width; row length = 2^COL_W words.
REQ-005 Parameter LEN_W, 10, burst length field width.
REQ-006 Parameters T_RCD, T_WR and T_RP, default 2 each, give tRCD, tWR and tRP in clk cycles; each SHALL be >= 1.
REQ-007 clk  in  1  clock; all logic is rising-edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 init_end  in  1  SDRAM initialisation done, level.
REQ-010 wr_en  in  1  write request, level, held until wr_end.
REQ-011 wr_addr  in  BANK_W+ROW_W+COL_W  start address {bank,row,col}; sampled at acceptance.
REQ-012 wr_bst_len  in  LEN_W  number of words to write; sampled at acceptance.
REQ-013 wr_data  in  DATA_W  write word; valid in every cycle where wr_ack=1.
REQ-014 wr_ack  out  1  current wr_data is consumed this cycle; the source advances on this edge.
REQ-015 wr_end  out  1  one-cycle pulse when the request completes.
REQ-016 wr_busy  out  1  high from acceptance through the wr_end cycle.
REQ-017 wr_sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}.
REQ-018 wr_sdram_bank  out  BANK_W  bank address.
REQ-019 wr_sdram_addr  out  ROW_W  row address, or zero-extended column address.
REQ-020 wr_sdram_en  out  1  DQ output enable.
REQ-021 wr_sdram_data  out  DATA_W  equals wr_data combinationally.

Function
REQ-022 Command encodings:
- NOP=0111
- ACT=0011
- WRITE=0100
- BURST_TERM=0110
- PRE=0010
- The SDRAM is in full-page burst mode.

REQ-023 States: IDLE, ACT, TRCD, WR, DATA, TERM, TWR, PRE, TRP, END.

REQ-024 Acceptance and IDLE:
- IDLE->ACT when wr_en=1, init_end=1 and wr_bst_len!=0.
- Acceptance latches the bank, row and column counters and the remaining count, and sets wr_busy.
- When wr_bst_len=0 the request is accepted with IDLE->END; no SDRAM command is issued.

REQ-025 ACT: issue ACT for one cycle with bank and row latched; go to TRCD.
REQ-026 TRCD: NOP for T_RCD-1 cycles, then go to WR; ACT-to-WRITE spacing = T_RCD cycles.

REQ-027 WR: issue WRITE for one cycle.
- wr_sdram_addr = zero-extended column with A10=0.
- wr_ack=1 and wr_sdram_en=1; first word transferred.

REQ-028 DATA: NOP, with wr_ack=1 and wr_sdram_en=1 on every cycle.
- Each word decrements remaining and increments the column.
- The phase runs until remaining reaches 0, or the column wraps to 0 (row end), whichever comes first.

REQ-029 TERM: issue BURST_TERM for one cycle, then go to TWR.
- wr_ack=0 and wr_sdram_en=0 in TERM and in every later state.

REQ-030 TWR: NOP for T_WR-1 cycles, then go to PRE.
REQ-031 PRE: issue PRE with A10=1 (all banks); go to TRP.

REQ-032 TRP: NOP for T_RP-1 cycles, then branch:
- remaining!=0 (row crossing): go to ACT using row+1, column 0.
- Row overflow increments the bank, modulo 2^BANK_W.
- remaining=0: go to END.

REQ-033 END: wr_end=1 for one cycle, then IDLE; wr_busy clears after this cycle.
REQ-034 A total of exactly wr_bst_len wr_ack cycles SHALL occur per request, including across row crossings.
REQ-035 Each row segment writes consecutive columns; no word is skipped or repeated at a crossing.
REQ-036 wr_en falling mid-burst SHALL be ignored; the request runs to completion.
REQ-037 wr_en still high after wr_end starts a new request only after one IDLE cycle.
REQ-038 init_end falling SHALL be ignored outside IDLE.
REQ-039 All state counters saturate and never wrap into an illegal state; an illegal state encoding SHALL return to IDLE.

Reset
REQ-040 On rst_n=0, state SHALL be IDLE immediately (asynchronously), mid-burst included.
REQ-041 Reset values:
- wr_sdram_cmd=0111
- wr_sdram_bank=0
- wr_sdram_addr=0
- wr_ack=0, wr_end=0, wr_busy=0, wr_sdram_en=0
- all counters 0.

REQ-042 After reset release, the block SHALL issue no command other than NOP until a request is accepted.

Verification
REQ-043 Defaults, addr 0x000000, len 10, data ramp 1..10 -> ACT row 0; WRITE 2 cycles later; 10 wr_ack cycles; BURST_TERM; PRE A10=1; wr_end; model memory cols 0..9 = 1..10.
REQ-044 addr {bank 1, row 5, col 508}, len 8 -> 4 words to row 5 cols 508..511; PRE; ACT row 6; 4 words to cols 0..3; 8 wr_ack total; one wr_end.
REQ-045 addr {bank 0, row 8191, col 511}, len 2 -> second segment ACT bank 1, row 0, col 0.
REQ-046 wr_bst_len=0 with wr_en=1 -> no non-NOP command; wr_end pulses within 2 cycles of acceptance.
REQ-047 rst_n asserted at the 3rd DATA cycle -> outputs reach reset values at once; after release, a fresh len-4 request completes correctly.
REQ-048 T_RCD=3, T_WR=2, T_RP=4 -> ACT-to-WRITE = 3 cycles; BURST_TERM-to-PRE = 2 cycles; PRE-to-next-ACT/END = 4 cycles.

Source files
------------

// File: rtl/sdram_burst_writer.sv
// SDRAM full-page burst writer: opens a row, streams words with one WRITE,
// stops the burst with BURST_TERM, precharges, and reopens the next row when
// a request crosses a row boundary.
module sdram_burst_writer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BANK_W = 2,
    parameter int unsigned ROW_W  = 13,
    parameter int unsigned COL_W  = 9,
    parameter int unsigned LEN_W  = 10,
    parameter int unsigned T_RCD  = 2,
    parameter int unsigned T_WR   = 2,
    parameter int unsigned T_RP   = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_init_end,
    input  logic                            i_wr_en,
    input  logic [BANK_W+ROW_W+COL_W-1:0]   i_wr_addr,
    input  logic [LEN_W-1:0]                i_wr_bst_len,
    input  logic [DATA_W-1:0]               i_wr_data,
    output logic                            o_wr_ack,
    output logic                            o_wr_end,
    output logic                            o_wr_busy,
    output logic [3:0]                      o_wr_sdram_cmd,
    output logic [BANK_W-1:0]               o_wr_sdram_bank,
    output logic [ROW_W-1:0]                o_wr_sdram_addr,
    output logic                            o_wr_sdram_en,
    output logic [DATA_W-1:0]               o_wr_sdram_data
);

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_BST   = 4'b0110;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    localparam int unsigned CNT_W = 8;
    // Wait counters are loaded with T-2 so that the wait state lasts T-1 cycles.
    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [CNT_W-1:0] WR_LD  = CNT_W'((T_WR > 1) ? T_WR - 2 : 0);
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'((T_RP > 1) ? T_RP - 2 : 0);

    typedef enum logic [3:0] {
        StIdle, StAct, StTrcd, StWr, StData, StTerm, StTwr, StPre, StTrp, StEnd
    } state_e;

    state_e               r_state, w_state_d;
    logic [BANK_W-1:0]    r_bank, w_bank_d;
    logic [ROW_W-1:0]     r_row, w_row_d;
    logic [COL_W-1:0]     r_col, w_col_d;
    logic [LEN_W-1:0]     r_remain, w_remain_d;
    logic [CNT_W-1:0]     r_cnt, w_cnt_d;

    logic [LEN_W-1:0]        w_remain_dec;
    logic [COL_W-1:0]        w_col_inc;
    logic [BANK_W+ROW_W-1:0] w_br_inc;
    logic [ROW_W-1:0]        w_col_addr;
    logic                    w_rp_done;

    assign w_remain_dec    = (r_remain != '0) ? r_remain - LEN_W'(1) : '0;
    assign w_col_inc       = r_col + COL_W'(1);
    // Row overflow carries into the bank, wrapping modulo the bank count.
    assign w_br_inc        = {r_bank, r_row} + (BANK_W+ROW_W)'(1);
    assign o_wr_sdram_data = i_wr_data;
    assign o_wr_busy       = (r_state != StIdle);

    // Column address for WRITE: zero-extended with A10 low (no auto-precharge).
    always_comb begin
        w_col_addr     = ROW_W'(r_col);
        w_col_addr[10] = 1'b0;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_bank   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_remain <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_bank   <= w_bank_d;
            r_row    <= w_row_d;
            r_col    <= w_col_d;
            r_remain <= w_remain_d;
            r_cnt    <= w_cnt_d;
        end
    end

    // Next-state, counter updates and command/handshake outputs.
    always_comb begin
        w_state_d       = r_state;
        w_bank_d        = r_bank;
        w_row_d         = r_row;
        w_col_d         = r_col;
        w_remain_d      = r_remain;
        w_cnt_d         = r_cnt;
        w_rp_done       = 1'b0;
        o_wr_sdram_cmd  = CMD_NOP;
        o_wr_sdram_bank = '0;
        o_wr_sdram_addr = '0;
        o_wr_ack        = 1'b0;
        o_wr_sdram_en   = 1'b0;
        o_wr_end        = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_wr_en && i_init_end) begin
                    w_col_d    = i_wr_addr[COL_W-1:0];
                    w_row_d    = i_wr_addr[COL_W +: ROW_W];
                    w_bank_d   = i_wr_addr[COL_W+ROW_W +: BANK_W];
                    w_remain_d = i_wr_bst_len;
                    w_cnt_d    = '0;
                    w_state_d  = (i_wr_bst_len != '0) ? StAct : StEnd;
                end
            end
            StAct: begin
                o_wr_sdram_cmd  = CMD_ACT;
                o_wr_sdram_bank = r_bank;
                o_wr_sdram_addr = r_row;
                w_cnt_d         = RCD_LD;
                w_state_d       = (T_RCD > 1) ? StTrcd : StWr;
            end
            StTrcd: begin
                if (r_cnt == '0) w_state_d = StWr;
                else             w_cnt_d   = r_cnt - CNT_W'(1);
            end
            StWr, StData: begin
                if (r_state == StWr) begin
                    o_wr_sdram_cmd  = CMD_WRITE;
                    o_wr_sdram_bank = r_bank;
                    o_wr_sdram_addr = w_col_addr;
                end
                o_wr_ack      = 1'b1;
                o_wr_sdram_en = 1'b1;
                w_remain_d    = w_remain_dec;
                w_col_d       = w_col_inc;
                // Stop at request end or at the last column of the open row.
                w_state_d     = (w_remain_dec == '0 || w_col_inc == '0) ? StTerm : StData;
            end
            StTerm: begin
                o_wr_sdram_cmd = CMD_BST;
                w_cnt_d        = WR_LD;
                w_state_d      = (T_WR > 1) ? StTwr : StPre;
            end
            StTwr: begin
                if (r_cnt == '0) w_state_d = StPre;
                else             w_cnt_d   = r_cnt - CNT_W'(1);
            end
            StPre: begin
                o_wr_sdram_cmd      = CMD_PRE;
                o_wr_sdram_bank     = r_bank;
                o_wr_sdram_addr[10] = 1'b1;
                w_cnt_d             = RP_LD;
                if (T_RP > 1) w_state_d = StTrp;
                else          w_rp_done = 1'b1;
            end
            StTrp: begin
                if (r_cnt == '0) w_rp_done = 1'b1;
                else             w_cnt_d   = r_cnt - CNT_W'(1);
            end
            StEnd: begin
                o_wr_end  = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        // After precharge: reopen at the next row for leftover words, else finish.
        if (w_rp_done) begin
            if (r_remain != '0) begin
                {w_bank_d, w_row_d} = w_br_inc;
                w_col_d             = '0;
                w_state_d           = StAct;
            end else begin
                w_state_d = StEnd;
            end
        end
    end

endmodule
